tm1638_responder: RTL and testbench
===================================

Name: tm1638_responder

Overview:
- Synthesizable model of the TM1638 chip side of the 3-wire serial link (STB/CLK/DIO) driven by the tm1638 controller.
- Oversamples the link in the system clock domain and decodes command and data bytes into a 16x8 display RAM and display-control registers.
- Serves key-scan reads by driving DIO.
- Used as a loopback target in benches and on-board self-test next to the controller.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for STB/CLK/DIO inputs (min 2).
- NUM_KEY_BYTES, 4, bytes returned per key-read frame (1..4).

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  synchronous, active-high reset
- i_SPI_Stb  input  1  strobe, active low
- i_SPI_Clk  input  1  serial clock, idle high
- i_SPI_Dio  input  1  serial data from controller
- o_SPI_Dio  output  1  serial data to controller
- o_SPI_Dio_En  output  1  DIO output enable (tri-state control)
- i_Keys  input  32  key matrix state; byte n = i_Keys[8n+7:8n]
- i_Ram_Rd_Addr  input  4  display RAM read address
- o_Ram_Rd_Data  output  8  display RAM read data, registered, 1-cycle latency
- o_Ram_Wr_En  output  1  one-cycle pulse per RAM write
- o_Ram_Wr_Addr  output  4  address of the current write
- o_Ram_Wr_Data  output  8  data of the current write
- o_Display_On  output  1  display control bit 3
- o_Brightness  output  3  display control bits [2:0]
- o_Frame_Error  output  1  one-cycle pulse on a protocol error

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst is synchronous, active-high.
- Synchronization: STB/CLK/DIO each pass SYNC_STAGES flops; CLK edges are detected on the synchronized signal.
- Link timing requirement: SPI half-period >= SYNC_STAGES+2 i_Clk cycles.
- Bit order: LSB first. Controller-to-responder bits are sampled on synced CLK rising edges.
- State machine:
  - IDLE: entered while STB is high. STB falling -> CMD, bit count = 0.
  - CMD: shift 8 bits, then decode the byte.
  - Decode [7:6]=01, data command: latch fixed-address mode from bit 2. Bit 1 = 1 -> snapshot i_Keys, go to RD_KEYS. Bit 1 = 0 -> go to IGNORE.
  - Decode [7:6]=10, display control: o_Display_On <= bit 3, o_Brightness <= bits [2:0]; go to IGNORE.
  - Decode [7:6]=11, address set: pointer <= bits [3:0]; go to WR_DATA.
  - Decode [7:6]=00: pulse o_Frame_Error; go to IGNORE.
  - WR_DATA: each completed byte is written to RAM[pointer]. o_Ram_Wr_En pulses with the address and data. Pointer increments mod 16 (15 -> 0) unless fixed-address mode is set.
  - RD_KEYS:
    - o_SPI_Dio_En asserts on the first synced CLK falling edge after the command byte.
    - o_SPI_Dio updates on each synced falling edge with the next snapshot bit, byte 0 first.
    - After NUM_KEY_BYTES*8 bits, o_SPI_Dio_En deasserts and the state moves to IGNORE.
  - IGNORE: CLK edges are ignored until STB rises.
- STB rising in any state -> IDLE, with o_SPI_Dio_En <= 0 in the same cycle.
  - If the partial bit count is nonzero in CMD or WR_DATA, the partial byte is discarded and o_Frame_Error pulses.
- Write latency: o_Ram_Wr_En asserts SYNC_STAGES+1 cycles after the pin-level CLK rising edge carrying bit 7.
- RAM read/write collision: if the read and write port hit the same address in the same cycle, read data returns the old value.
- Persistence: fixed-address mode, pointer, display control and RAM persist across frames.
- Reset values:
  - All outputs 0.
  - RAM cleared over 16 cycles after reset; writes arriving during the clear are dropped.
  - Mode = auto-increment, pointer = 0, state = IDLE.
- Reset mid-frame: immediate return to IDLE; any partial byte is dropped with no error pulse.

Optional Feature:
- Macro: TM1638_RESPONDER_DIAG_EN.
- Defined: adds outputs o_Diag_State (3 bits; IDLE=0, CMD=1, WR_DATA=2, RD_KEYS=3, IGNORE=4) and o_Diag_Byte_Count (8 bits, bytes completed in the current frame, saturating at 255, cleared on STB falling).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Frame 0x40; frame 0xC0, 0x3F, 0x06 -> Wr pulses (0,0x3F), (1,0x06); RAM[0]=0x3F, RAM[1]=0x06, no error.
- Frame 0x44; frame 0xC5, 0xAA, 0x55 -> both writes to address 5; RAM[5]=0x55, RAM[6] unchanged.
- Frame 0xC0 followed by 17 bytes 0x00..0x10 -> pointer wraps; RAM[0]=0x10, RAM[15]=0x0F.
- i_Keys=0x8040_2001, frame 0x42 then 32 CLK pulses -> controller reads bytes 0x01, 0x20, 0x40, 0x80; Dio_En drops after bit 31 and on STB high.
- Frame 0x8F -> o_Display_On=1, o_Brightness=7; frame 0x00 -> o_Frame_Error pulses, control unchanged.
- STB rises after 5 bits of a data byte -> no write, one o_Frame_Error pulse; i_Rst mid-frame -> all outputs 0 and the next 0xC0 frame decodes normally.

Source files
------------

// File: rtl/tm1638_responder.sv
// tm1638_responder: chip-side model of the TM1638 STB/CLK/DIO link, oversampled in the i_Clk domain.
// Decodes command/data bytes into a 16x8 display RAM and display control; drives DIO for key-scan reads.
// Optional diagnostics (state, byte count) are built when TM1638_RESPONDER_DIAG_EN is defined.
module tm1638_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_KEY_BYTES = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_SPI_Stb,
  input  logic        i_SPI_Clk,
  input  logic        i_SPI_Dio,
  output logic        o_SPI_Dio,
  output logic        o_SPI_Dio_En,
  input  logic [31:0] i_Keys,
  input  logic [3:0]  i_Ram_Rd_Addr,
  output logic [7:0]  o_Ram_Rd_Data,
  output logic        o_Ram_Wr_En,
  output logic [3:0]  o_Ram_Wr_Addr,
  output logic [7:0]  o_Ram_Wr_Data,
  output logic        o_Display_On,
  output logic [2:0]  o_Brightness,
  output logic        o_Frame_Error
`ifdef TM1638_RESPONDER_DIAG_EN
  ,
  output logic [2:0]  o_Diag_State,
  output logic [7:0]  o_Diag_Byte_Count
`endif
);

  localparam logic [5:0] KEY_BITS = 6'(NUM_KEY_BYTES * 8);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_KEYS = 3'd3,
    S_IGNORE  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dio_sync;
  logic                   r_stb_prev;
  logic                   r_clk_prev;

  logic w_stb;
  logic w_clk;
  logic w_dio;
  logic w_stb_rise;
  logic w_stb_fall;
  logic w_clk_rise;
  logic w_clk_fall;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_fixed;
  logic [3:0]  r_ptr;
  logic [31:0] r_keys;
  logic [5:0]  r_key_cnt;
  logic [7:0]  w_byte;

  logic [7:0]  r_ram [16];
  logic        r_clearing;
  logic [3:0]  r_clr_addr;

  // Input synchronizers; STB/CLK reset to their idle-high level so reset never fakes an edge
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_stb_sync <= '1;
      r_clk_sync <= '1;
      r_dio_sync <= '0;
      r_stb_prev <= 1'b1;
      r_clk_prev <= 1'b1;
    end else begin
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], i_SPI_Stb};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], i_SPI_Dio};
      r_stb_prev <= w_stb;
      r_clk_prev <= w_clk;
    end
  end

  assign w_stb      = r_stb_sync[SYNC_STAGES-1];
  assign w_clk      = r_clk_sync[SYNC_STAGES-1];
  assign w_dio      = r_dio_sync[SYNC_STAGES-1];
  assign w_stb_rise = ~r_stb_prev & w_stb;
  assign w_stb_fall = r_stb_prev & ~w_stb;
  assign w_clk_rise = ~r_clk_prev & w_clk;
  assign w_clk_fall = r_clk_prev & ~w_clk;

  // Byte being completed by the current rising edge (LSB arrives first)
  assign w_byte = {w_dio, r_shift[7:1]};

  // Protocol state machine with registered outputs; STB high always wins over CLK activity
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_fixed       <= 1'b0;
      r_ptr         <= '0;
      r_keys        <= '0;
      r_key_cnt     <= '0;
      o_SPI_Dio     <= 1'b0;
      o_SPI_Dio_En  <= 1'b0;
      o_Ram_Wr_En   <= 1'b0;
      o_Ram_Wr_Addr <= '0;
      o_Ram_Wr_Data <= '0;
      o_Display_On  <= 1'b0;
      o_Brightness  <= '0;
      o_Frame_Error <= 1'b0;
    end else begin
      o_Ram_Wr_En   <= 1'b0;
      o_Frame_Error <= 1'b0;
      if (w_stb_rise) begin
        // A frame ending mid-byte loses the partial byte and is flagged
        if ((r_state == S_CMD || r_state == S_WR_DATA) && r_bit_cnt != 3'd0)
          o_Frame_Error <= 1'b1;
        r_state      <= S_IDLE;
        r_bit_cnt    <= '0;
        o_SPI_Dio_En <= 1'b0;
      end else if (w_stb) begin
        r_state      <= S_IDLE;
        r_bit_cnt    <= '0;
        o_SPI_Dio_En <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_stb_fall) begin
              r_state   <= S_CMD;
              r_bit_cnt <= '0;
            end
          end
          S_CMD: begin
            if (w_clk_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                case (w_byte[7:6])
                  2'b01: begin
                    r_fixed <= w_byte[2];
                    if (w_byte[1]) begin
                      r_keys    <= i_Keys;
                      r_key_cnt <= '0;
                      r_state   <= S_RD_KEYS;
                    end else begin
                      r_state <= S_IGNORE;
                    end
                  end
                  2'b10: begin
                    o_Display_On <= w_byte[3];
                    o_Brightness <= w_byte[2:0];
                    r_state      <= S_IGNORE;
                  end
                  2'b11: begin
                    r_ptr   <= w_byte[3:0];
                    r_state <= S_WR_DATA;
                  end
                  default: begin
                    o_Frame_Error <= 1'b1;
                    r_state       <= S_IGNORE;
                  end
                endcase
              end
            end
          end
          S_WR_DATA: begin
            if (w_clk_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                // Writes landing while the RAM is still being cleared are dropped
                if (!r_clearing) begin
                  o_Ram_Wr_En   <= 1'b1;
                  o_Ram_Wr_Addr <= r_ptr;
                  o_Ram_Wr_Data <= w_byte;
                end
                if (!r_fixed)
                  r_ptr <= r_ptr + 4'd1;
              end
            end
          end
          S_RD_KEYS: begin
            // Drive on falling edges; release after the controller samples the last bit
            if (w_clk_fall && r_key_cnt != KEY_BITS) begin
              o_SPI_Dio_En <= 1'b1;
              o_SPI_Dio    <= r_keys[r_key_cnt[4:0]];
              r_key_cnt    <= r_key_cnt + 6'd1;
            end else if (w_clk_rise && r_key_cnt == KEY_BITS) begin
              o_SPI_Dio_En <= 1'b0;
              r_state      <= S_IGNORE;
            end
          end
          S_IGNORE: begin
            r_state <= S_IGNORE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Post-reset clear sequencer: one RAM word per cycle for 16 cycles
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_clearing <= 1'b1;
      r_clr_addr <= '0;
    end else if (r_clearing) begin
      r_clr_addr <= r_clr_addr + 4'd1;
      if (r_clr_addr == 4'd15)
        r_clearing <= 1'b0;
    end
  end

  // RAM storage (no reset on the array); writes commit the cycle after the Wr_En pulse is presented
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      if (r_clearing)
        r_ram[r_clr_addr] <= 8'h00;
      else if (o_Ram_Wr_En)
        r_ram[o_Ram_Wr_Addr] <= o_Ram_Wr_Data;
    end
  end

  // Registered read port; a same-cycle write to the same address returns the old word
  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      o_Ram_Rd_Data <= '0;
    else
      o_Ram_Rd_Data <= r_ram[i_Ram_Rd_Addr];
  end

`ifdef TM1638_RESPONDER_DIAG_EN
  logic [7:0] r_diag_bytes;
  logic       w_byte_done;

  assign w_byte_done = ~w_stb & w_clk_rise &
                       (((r_state == S_CMD || r_state == S_WR_DATA) && r_bit_cnt == 3'd7) ||
                        (r_state == S_RD_KEYS && r_key_cnt != 6'd0 && r_key_cnt[2:0] == 3'd0));

  // Saturating count of bytes completed in the current frame
  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      r_diag_bytes <= '0;
    else if (w_stb_fall)
      r_diag_bytes <= '0;
    else if (w_byte_done && r_diag_bytes != 8'hFF)
      r_diag_bytes <= r_diag_bytes + 8'd1;
  end

  assign o_Diag_State      = r_state;
  assign o_Diag_Byte_Count = r_diag_bytes;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: drives the 3-wire link like a controller and checks RAM, control,
// key reads and error pulses against a frame-level model of the command set.
module tb_tm1638_responder;
  localparam int HP = 6;  // link half-period in i_Clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b1;
  logic        sclk = 1'b1;
  logic        sdio = 1'b0;
  logic [31:0] keys = '0;
  logic [3:0]  rd_addr = '0;
  logic        dio_o, dio_en, wr_en, disp_on, ferr;
  logic [7:0]  rd_data, wr_data;
  logic [3:0]  wr_addr;
  logic [2:0]  bright;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  logic [11:0] wr_q[$];

  // Frame-level reference model
  logic [7:0]  m_ram [16];
  bit          m_fixed;
  logic [3:0]  m_ptr;
  bit          m_on;
  logic [2:0]  m_br;
  logic [11:0] exp_q[$];
  int          exp_err;
  logic [7:0]  fq[$];

  tm1638_responder dut (
    .i_Clk(clk), .i_Rst(rst), .i_SPI_Stb(stb), .i_SPI_Clk(sclk), .i_SPI_Dio(sdio),
    .o_SPI_Dio(dio_o), .o_SPI_Dio_En(dio_en), .i_Keys(keys),
    .i_Ram_Rd_Addr(rd_addr), .o_Ram_Rd_Data(rd_data),
    .o_Ram_Wr_En(wr_en), .o_Ram_Wr_Addr(wr_addr), .o_Ram_Wr_Data(wr_data),
    .o_Display_On(disp_on), .o_Brightness(bright), .o_Frame_Error(ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (ferr) err_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; sdio = b[i]; cyc(HP);
      sclk = 1'b1; cyc(HP);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++) m_ram[a] = 8'h00;
    m_fixed = 0; m_ptr = '0; m_on = 0; m_br = '0;
  endtask

  task automatic model_frame();
    logic [7:0] c;
    c = fq[0];
    case (c[7:6])
      2'b01: m_fixed = c[2];
      2'b10: begin m_on = c[3]; m_br = c[2:0]; end
      2'b11: begin
        m_ptr = c[3:0];
        for (int i = 1; i < fq.size(); i++) begin
          exp_q.push_back({m_ptr, fq[i]});
          m_ram[m_ptr] = fq[i];
          if (!m_fixed) m_ptr = m_ptr + 4'd1;
        end
      end
      default: exp_err = 1;
    endcase
  endtask

  task automatic run_frame(input string name);
    int e0;
    exp_q.delete(); exp_err = 0;
    model_frame();
    wr_q.delete(); e0 = err_seen;
    stb = 1'b0; cyc(HP);
    foreach (fq[i]) send_bits(fq[i], 8);
    cyc(HP); stb = 1'b1; cyc(HP + 4);
    n_cmp++;
    if (wr_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL %s_wr_count: got %0d expected %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL %s_wr[%0d]: got addr/data %h expected %h", name, i, wr_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (err_seen - e0 !== exp_err) begin
      n_bad++; $display("FAIL %s_err: got %0d pulses expected %0d", name, err_seen - e0, exp_err);
    end
  endtask

  task automatic check_ram(input string name);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); cyc(2);
      n_cmp++;
      if (rd_data !== m_ram[a]) begin
        n_bad++; $display("FAIL %s_ram[%0d]: got %h expected %h", name, a, rd_data, m_ram[a]);
      end
    end
  endtask

  task automatic check_ctrl(input string name);
    n_cmp++;
    if ({disp_on, bright} !== {m_on, m_br}) begin
      n_bad++; $display("FAIL %s_ctrl: got on=%b br=%0d expected on=%b br=%0d", name, disp_on, bright, m_on, m_br);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_cmp++;
    if ({dio_o, dio_en, wr_en, wr_addr, wr_data, disp_on, bright, ferr, rd_data} !== 30'd0) begin
      n_bad++;
      $display("FAIL %s_outputs: got dio=%b en=%b wr=%b wa=%h wd=%h on=%b br=%0d err=%b rd=%h expected all 0",
               name, dio_o, dio_en, wr_en, wr_addr, wr_data, disp_on, bright, ferr, rd_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(4);
    check_zero_outputs("reset");
    rst = 1'b0; cyc(24);
    model_reset();
    check_zero_outputs("post_reset");
    check_ram("reset_clear");
  endtask

  task automatic test_auto_write();
    fq = '{8'h40}; run_frame("auto_cmd");
    fq = '{8'hC0, 8'h3F, 8'h06}; run_frame("auto_data");
    check_ram("auto");
  endtask

  task automatic test_fixed();
    fq = '{8'h44}; run_frame("fixed_cmd");
    fq = '{8'hC5, 8'hAA, 8'h55}; run_frame("fixed_data");
    check_ram("fixed");
  endtask

  task automatic test_wrap();
    fq = '{8'h40}; run_frame("wrap_cmd");
    fq = '{8'hC0};
    for (int i = 0; i <= 16; i++) fq.push_back(8'(i));
    run_frame("wrap_data");
    check_ram("wrap");
  endtask

  task automatic test_keys();
    logic [31:0] kexp;
    logic [7:0]  got;
    bit          en_ok;
    int          e0;
    for (int it = 0; it < 2; it++) begin
      kexp = (it == 0) ? 32'h8040_2001 : $urandom();
      keys = kexp;
      e0 = err_seen;
      stb = 1'b0; cyc(HP);
      send_bits(8'h42, 8);
      m_fixed = 0;
      keys = ~kexp;  // the frame must return the snapshot, not live keys
      n_cmp++;
      if (dio_en !== 1'b0) begin
        n_bad++; $display("FAIL keys_en_early: got %b expected 0", dio_en);
      end
      for (int n = 0; n < 4; n++) begin
        got = '0; en_ok = 1;
        for (int i = 0; i < 8; i++) begin
          sclk = 1'b0; cyc(HP);
          got[i] = dio_o;
          if (dio_en !== 1'b1) en_ok = 0;
          sclk = 1'b1; cyc(HP);
        end
        n_cmp++;
        if (got !== kexp[8*n +: 8]) begin
          n_bad++; $display("FAIL keys_byte%0d: got %h expected %h", n, got, kexp[8*n +: 8]);
        end
        n_cmp++;
        if (!en_ok) begin
          n_bad++; $display("FAIL keys_en_byte%0d: got enable low during read expected high", n);
        end
      end
      n_cmp++;
      if (dio_en !== 1'b0) begin
        n_bad++; $display("FAIL keys_en_after_last: got %b expected 0", dio_en);
      end
      cyc(HP); stb = 1'b1; cyc(HP + 4);
      n_cmp++;
      if (err_seen - e0 !== 0) begin
        n_bad++; $display("FAIL keys_err: got %0d pulses expected 0", err_seen - e0);
      end
    end
    // STB rising in the middle of a key read releases DIO
    stb = 1'b0; cyc(HP);
    send_bits(8'h42, 8);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b0; cyc(HP); sclk = 1'b1; cyc(HP);
    end
    n_cmp++;
    if (dio_en !== 1'b1) begin
      n_bad++; $display("FAIL keys_en_mid: got %b expected 1", dio_en);
    end
    stb = 1'b1; cyc(HP);
    n_cmp++;
    if (dio_en !== 1'b0) begin
      n_bad++; $display("FAIL keys_en_stb: got %b expected 0", dio_en);
    end
  endtask

  task automatic test_display();
    fq = '{8'h8F}; run_frame("disp_on");
    check_ctrl("disp_on");
    fq = '{8'h00}; run_frame("disp_bad");
    check_ctrl("disp_bad");
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = err_seen; wr_q.delete();
    stb = 1'b0; cyc(HP);
    send_bits(8'hC3, 8);
    send_bits(8'hFF, 3);
    rst = 1'b1; cyc(2);
    check_zero_outputs("rst_mid");
    stb = 1'b1; sclk = 1'b1; cyc(3);
    rst = 1'b0; cyc(24);
    model_reset();
    check_zero_outputs("rst_mid_after");
    n_cmp++;
    if ((err_seen - e0) !== 0 || wr_q.size() !== 0) begin
      n_bad++; $display("FAIL rst_mid_side: got %0d errs %0d writes expected 0 0", err_seen - e0, wr_q.size());
    end
    fq = '{8'hC0, 8'h77}; run_frame("rst_mid_next");
    check_ram("rst_mid");
  endtask

  task automatic test_latency();
    int lat;
    fq = '{8'hC7, 8'h11}; run_frame("lat_pre");
    rd_addr = 4'd7; wr_q.delete();
    stb = 1'b0; cyc(HP);
    send_bits(8'hC7, 8);
    send_bits(8'hE2, 7);
    sclk = 1'b0; sdio = 1'b1; cyc(HP);
    sclk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (wr_en) begin lat = k; break; end
    end
    n_cmp++;
    if (lat !== 3) begin
      n_bad++; $display("FAIL wr_latency: got %0d cycles expected 3 (0 = no pulse)", lat);
    end
    n_cmp++;
    if ({wr_addr, wr_data} !== {4'd7, 8'hE2}) begin
      n_bad++; $display("FAIL lat_wr: got %h/%h expected 7/e2", wr_addr, wr_data);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_data !== 8'h11) begin
      n_bad++; $display("FAIL collision_old: got %h expected 11", rd_data);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_data !== 8'hE2) begin
      n_bad++; $display("FAIL collision_new: got %h expected e2", rd_data);
    end
    cyc(HP); stb = 1'b1; cyc(HP + 4);
    m_ram[7] = 8'hE2;
    if (!m_fixed) m_ptr = 4'd8;
  endtask

  task automatic test_abort();
    int e0;
    e0 = err_seen; wr_q.delete();
    stb = 1'b0; cyc(HP);
    send_bits(8'hC0, 8);
    send_bits(8'h5A, 5);
    cyc(HP); stb = 1'b1; cyc(HP + 4);
    m_ptr = 4'd0;
    n_cmp++;
    if (wr_q.size() !== 0) begin
      n_bad++; $display("FAIL abort_wr: got %0d writes expected 0", wr_q.size());
    end
    n_cmp++;
    if (err_seen - e0 !== 1) begin
      n_bad++; $display("FAIL abort_err: got %0d pulses expected 1", err_seen - e0);
    end
    check_ram("abort");
  endtask

  task automatic test_random();
    logic [7:0] c;
    int sel;
    for (int it = 0; it < 14; it++) begin
      fq.delete();
      sel = $urandom_range(0, 9);
      if (sel <= 1) begin
        c = 8'h40; c[2] = 1'($urandom_range(0, 1)); fq.push_back(c);
      end else if (sel == 2) begin
        c = 8'h80; c[3:0] = 4'($urandom_range(0, 15)); fq.push_back(c);
      end else if (sel == 3) begin
        c = 8'($urandom_range(0, 63)); fq.push_back(c);
      end else begin
        c = 8'hC0; c[3:0] = 4'($urandom_range(0, 15)); fq.push_back(c);
        for (int n = 0; n < $urandom_range(1, 10); n++) fq.push_back(8'($urandom()));
      end
      run_frame($sformatf("rand%0d", it));
    end
    check_ram("rand");
    check_ctrl("rand");
  endtask

  initial begin
    test_reset();
    test_auto_write();
    test_fixed();
    test_wrap();
    test_keys();
    test_display();
    test_reset_mid();
    test_latency();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
